// File: rtl/cambus_tx.sv
// cambus_tx: camera-bus transmitter emulating a parallel image sensor.
// Define CAMBUS_TX_TESTPAT_EN to add the internal (x + y) test-pattern source.
module cambus_tx #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 32,
    parameter int V_ACTIVE = 256,
    parameter int V_BLANK  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] in_pixel,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        cam_clk,
    output logic [11:0] cam_pixel,
    output logic        cam_hsync,
    output logic        cam_vsync,
    output logic        underrun,
    output logic        sof_err,
    input  logic        show_test_pattern
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [11:0] X_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] X_LAST     = 12'(H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0] Y_ACT_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] Y_VB_LAST  = 12'(V_BLANK - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t        state, state_n;
    logic [11:0]   x, y, x_n, y_n;
    logic [DW-1:0] div_cnt;
    logic          div_last, load;
    logic          next_act, frame_start, tp_now;
    logic          slot_fill, accept, sof_bad;
    logic [11:0]   pix_n;

    assign div_last = (div_cnt == DIV_MAX);
    // load is the cycle whose closing edge drops cam_clk
    assign load     = cam_clk & div_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            cam_clk <= 1'b0;
        end else if (div_last) begin
            div_cnt <= '0;
            cam_clk <= ~cam_clk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = ACTIVE;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            ACTIVE, HBLANK: begin
                if (x == X_LAST) begin
                    x_n = '0;
                    if (y == Y_ACT_LAST) begin
                        state_n = VBLANK;
                        y_n     = '0;
                    end else begin
                        state_n = ACTIVE;
                        y_n     = y + 12'd1;
                    end
                end else begin
                    x_n     = x + 12'd1;
                    state_n = (x_n < X_ACT) ? ACTIVE : HBLANK;
                end
            end
            VBLANK: begin
                if (x == X_LAST) begin
                    x_n = '0;
                    if (y == Y_VB_LAST) begin
                        y_n     = '0;
                        state_n = enable ? ACTIVE : IDLE;
                    end else begin
                        y_n = y + 12'd1;
                    end
                end else begin
                    x_n = x + 12'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign next_act    = (state_n == ACTIVE);
    assign frame_start = next_act &&
                         (state == IDLE || state == VBLANK);

`ifdef CAMBUS_TX_TESTPAT_EN
    logic tp_sel;

    always_ff @(posedge clk) begin
        if (!rst)
            tp_sel <= 1'b0;
        else if (load && frame_start)
            tp_sel <= show_test_pattern;
    end

    // the first slot of a frame already follows the new selection
    assign tp_now = frame_start ? show_test_pattern : tp_sel;
`else
    logic unused_tp;

    assign unused_tp = show_test_pattern ^ frame_start;
    assign tp_now    = 1'b0;
`endif

    assign slot_fill = load & next_act & ~tp_now;
    assign in_ready  = rst & slot_fill;
    assign accept    = in_ready & in_valid;
    assign sof_bad   = in_sof != ((x_n == 12'd0) && (y_n == 12'd0));

    always_comb begin
        pix_n = '0;
        if (next_act) begin
            if (tp_now)
                pix_n = x_n + y_n;
            else if (in_valid)
                pix_n = in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            cam_pixel <= '0;
            cam_hsync <= 1'b0;
            cam_vsync <= 1'b0;
            underrun  <= 1'b0;
            sof_err   <= 1'b0;
        end else if (load) begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            cam_pixel <= pix_n;
            cam_hsync <= next_act;
            cam_vsync <= next_act || (state_n == HBLANK);
            if (slot_fill && !in_valid)
                underrun <= 1'b1;
            if (accept && sof_bad)
                sof_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cambus_tx.sv
// tb_cambus_tx: table-driven frames, directed corner sequences and a
// randomized run checked against a slot-index model of the camera bus.
module tb_cambus_tx;
    localparam int CD    = 2;
    localparam int HA    = 4;
    localparam int HB    = 2;
    localparam int VA    = 3;
    localparam int VB    = 1;
    localparam int LINE  = HA + HB;
    localparam int FRAME = (VA + VB) * LINE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] in_pixel = '0;
    logic        in_sof = 1'b0;
    logic        in_valid = 1'b0;
    logic        show_test_pattern = 1'b0;
    logic        in_ready, cam_clk, cam_hsync, cam_vsync;
    logic        underrun, sof_err;
    logic [11:0] cam_pixel;

    cambus_tx #(
        .CLK_DIV (CD),
        .H_ACTIVE(HA),
        .H_BLANK (HB),
        .V_ACTIVE(VA),
        .V_BLANK (VB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .in_pixel         (in_pixel),
        .in_sof           (in_sof),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .cam_clk          (cam_clk),
        .cam_pixel        (cam_pixel),
        .cam_hsync        (cam_hsync),
        .cam_vsync        (cam_vsync),
        .underrun         (underrun),
        .sof_err          (sof_err),
        .show_test_pattern(show_test_pattern)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: slot index within the frame, -1 when idle
    int          m_n;
    int          m_slot;
    bit          m_tp;
    logic        m_clk, m_hs, m_vs, m_ur, m_se;
    logic [11:0] m_pix;

    // directed source and observation state
    bit          src_dir;
    int          act_idx, next_pix, skip_idx, sof_a, sof_b;
    int          hs_cnt, vs_cnt, rdy_cnt, fall_cnt, first_fall, last_vs;
    logic        prev_clk;
    logic [11:0] got_pix[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int next_slot(int s, logic en);
        if (s < 0 || s == FRAME - 1)
            return en ? 0 : -1;
        return s + 1;
    endfunction

    function automatic bit slot_active(int s);
        return (s >= 0) && ((s / LINE) < VA) && ((s % LINE) < HA);
    endfunction

    function automatic bit is_load();
        return ((m_n + 1) % (2 * CD)) == 0;
    endfunction

    function automatic bit tp_for(int nxt);
`ifdef CAMBUS_TX_TESTPAT_EN
        return (nxt == 0) ? bit'(show_test_pattern) : m_tp;
`else
        return (nxt < -1);
`endif
    endfunction

    function automatic logic m_ready();
        int nxt;
        nxt = next_slot(m_slot, enable);
        return is_load() && slot_active(nxt) && !tp_for(nxt);
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_slot = -1;
        m_tp   = 0;
        m_clk  = 0;
        m_hs   = 0;
        m_vs   = 0;
        m_ur   = 0;
        m_se   = 0;
        m_pix  = '0;
    endtask

    task automatic model_edge();
        int nxt;
        bit tp;
        if (!rst) begin
            model_reset();
            return;
        end
        if (is_load()) begin
            nxt    = next_slot(m_slot, enable);
            tp     = tp_for(nxt);
            if (nxt == 0)
                m_tp = tp;
            m_slot = nxt;
            m_hs   = slot_active(nxt);
            m_vs   = (nxt >= 0) && ((nxt / LINE) < VA);
            m_pix  = '0;
            if (m_hs) begin
                if (tp) begin
                    m_pix = 12'((nxt % LINE) + (nxt / LINE));
                end else if (in_valid) begin
                    m_pix = in_pixel;
                    if (in_sof != (nxt == 0))
                        m_se = 1;
                end else begin
                    m_ur = 1;
                end
            end
        end
        m_n++;
        m_clk = ((m_n / CD) % 2) == 1;
    endtask

    task automatic tick();
        logic rdy;
        #1;
        rdy = in_ready;
        if (src_dir && rdy) begin
            act_idx++;
            in_valid = (act_idx != skip_idx);
            in_pixel = 12'(next_pix);
            in_sof   = (act_idx == sof_a) || (act_idx == sof_b);
        end
        if (rst)
            check("in_ready", {31'd0, rdy}, {31'd0, m_ready()});
        @(posedge clk);
        if (src_dir && rdy && in_valid)
            next_pix++;
        model_edge();
        @(negedge clk);
        check("outputs",
              {15'd0, cam_clk, cam_hsync, cam_vsync, underrun, sof_err, cam_pixel},
              {15'd0, m_clk, m_hs, m_vs, m_ur, m_se, m_pix});
        if (rdy)
            rdy_cnt++;
        if (cam_hsync)
            hs_cnt++;
        if (cam_vsync) begin
            vs_cnt++;
            last_vs = m_n;
        end
        if (prev_clk && !cam_clk) begin
            fall_cnt++;
            if (first_fall < 0)
                first_fall = m_n;
            if (cam_hsync)
                got_pix.push_back(cam_pixel);
        end
        prev_clk = cam_clk;
    endtask

    task automatic clr_stats();
        hs_cnt     = 0;
        vs_cnt     = 0;
        rdy_cnt    = 0;
        fall_cnt   = 0;
        first_fall = -1;
        last_vs    = -1;
        got_pix.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clr_stats();
    endtask

    task automatic src_setup(int skip, int sa, int sb);
        src_dir  = 1;
        act_idx  = 0;
        next_pix = 1;
        skip_idx = skip;
        sof_a    = sa;
        sof_b    = sb;
        in_valid = 1'b1;
        in_sof   = 1'b0;
    endtask

    typedef struct {
        int   skip;
        int   sof_a;
        int   sof_b;
        logic exp_ur;
        logic exp_se;
    } row_t;

    row_t rows[6];

    initial begin
        int exp_p, start;
        model_reset();
        prev_clk = 1'b0;
        src_dir  = 0;
        clr_stats();

        rows[0] = '{skip: 0,  sof_a: 1, sof_b: 0, exp_ur: 1'b0, exp_se: 1'b0};
        rows[1] = '{skip: 6,  sof_a: 1, sof_b: 0, exp_ur: 1'b1, exp_se: 1'b0};
        rows[2] = '{skip: 0,  sof_a: 1, sof_b: 3, exp_ur: 1'b0, exp_se: 1'b1};
        rows[3] = '{skip: 1,  sof_a: 1, sof_b: 0, exp_ur: 1'b1, exp_se: 1'b0};
        rows[4] = '{skip: 12, sof_a: 1, sof_b: 0, exp_ur: 1'b1, exp_se: 1'b0};
        rows[5] = '{skip: 0,  sof_a: 0, sof_b: 0, exp_ur: 1'b0, exp_se: 1'b1};

        // idle with enable low: free-running divider only
        reset_dut();
        enable = 1'b0;
        for (int c = 0; c < 50; c++)
            tick();
        check("idle_first_fall", first_fall, 4);
        check("idle_fall_count", fall_cnt, 12);
        check("idle_ready_seen", rdy_cnt, 0);
        check("idle_sync_seen", hs_cnt + vs_cnt, 0);

        // one frame per table row
        foreach (rows[r]) begin
            reset_dut();
            src_setup(rows[r].skip, rows[r].sof_a, rows[r].sof_b);
            enable = 1'b1;
            for (int c = 0; c < 150; c++) begin
                if (m_n == 10)
                    enable = 1'b0;
                tick();
            end
            check("row_pix_count", got_pix.size(), HA * VA);
            for (int i = 1; i <= HA * VA && i <= got_pix.size(); i++) begin
                if (i == rows[r].skip)
                    exp_p = 0;
                else if (rows[r].skip > 0 && i > rows[r].skip)
                    exp_p = i - 1;
                else
                    exp_p = i;
                check("row_pixel", got_pix[i-1], exp_p);
            end
            check("row_hsync_cycles", hs_cnt, HA * VA * 2 * CD);
            check("row_vsync_cycles", vs_cnt, LINE * VA * 2 * CD);
            check("row_underrun", underrun, rows[r].exp_ur);
            check("row_sof_err", sof_err, rows[r].exp_se);
        end

        // enable dropped on line 1: frame and its vblank still complete
        reset_dut();
        src_setup(0, 1, 0);
        enable = 1'b1;
        for (int c = 0; c < 130; c++) begin
            if (m_n == 30)
                enable = 1'b0;
            tick();
        end
        check("drop_vsync_cycles", vs_cnt, 72);
        check("drop_hsync_cycles", hs_cnt, 48);
        check("drop_last_vsync", last_vs, 75);
        check("drop_ready_count", rdy_cnt, 12);
        check("drop_idle_sync", {cam_hsync, cam_vsync}, 2'b00);

        // second run, reset mid-frame at cycle 40
        clr_stats();
        src_setup(1, 2, 0);
        enable = 1'b1;
        start  = m_n;
        for (int c = 0; c < 200 && m_n < start + 40; c++)
            tick();
        check("run2_underrun_set", underrun, 1'b1);
        check("run2_vsync_mid", cam_vsync, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("reset_clears",
              {cam_clk, cam_hsync, cam_vsync, underrun, sof_err, cam_pixel},
              17'd0);
        #1;
        check("reset_ready", in_ready, 1'b0);
        enable = 1'b0;

`ifdef CAMBUS_TX_TESTPAT_EN
        reset_dut();
        src_dir           = 0;
        in_valid          = 1'b1;
        in_pixel          = 12'hABC;
        show_test_pattern = 1'b1;
        enable            = 1'b1;
        for (int c = 0; c < 110; c++) begin
            if (m_n == 10)
                enable = 1'b0;
            tick();
        end
        check("tp_pix_count", got_pix.size(), HA * VA);
        for (int i = 0; i < HA && HA + i < got_pix.size(); i++)
            check("tp_line1", got_pix[HA + i], i + 1);
        check("tp_ready_seen", rdy_cnt, 0);
        show_test_pattern = 1'b0;
`endif

        // randomized traffic against the model
        reset_dut();
        src_dir = 0;
        enable  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0)
                enable = ~enable;
            if ($urandom_range(0, 199) == 0)
                show_test_pattern = ~show_test_pattern;
            rst      = ($urandom_range(0, 599) != 0);
            in_valid = ($urandom_range(0, 9) != 0);
            in_pixel = 12'($urandom);
            in_sof   = (next_slot(m_slot, enable) == 0) ^
                       ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cambus_tx.md
Name: cambus_tx

Overview:
- Camera-bus transmitter/emulator: the far end of the camera interface the capture path receives.
- Takes a pixel stream on the 50MHz `clk` domain via valid/ready.
- Generates `cam_clk`, `cam_pixel`, `cam_hsync` and `cam_vsync` with fixed line/frame timing.
- Used to drive the capture path (loopback or bench) without a physical camera, and as a video source for downstream bring-up.

Parameters:
- CLK_DIV, 2: half-period of `cam_clk` in `clk` cycles (min 1); one pixel slot = 2*CLK_DIV cycles.
- H_ACTIVE, 320: active pixel slots per line.
- H_BLANK, 32: blank slots per line (min 1).
- V_ACTIVE, 256: active lines per frame.
- V_BLANK, 4: blank lines per frame (min 1).

Ports:
- clk  in  1  50MHz system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- enable  in  1  frames start only while high
- in_pixel  in  12  pixel data from source
- in_sof  in  1  marks first pixel of a frame
- in_valid  in  1  source has pixel
- in_ready  out  1  block accepts pixel this cycle
- cam_clk  out  1  generated camera pixel clock
- cam_pixel  out  12  pixel data, changes on `cam_clk` falling edge
- cam_hsync  out  1  line-valid, high during active pixels of active lines
- cam_vsync  out  1  frame-valid, high for all slots of active lines
- underrun  out  1  sticky: active slot had no valid pixel
- sof_err  out  1  sticky: in_sof misplaced
- show_test_pattern  in  1  select internal pattern (see Optional Feature)

Behaviour:
- Reset (`rst`=0 at a `clk` edge) clears all outputs and state: `cam_clk`=0, `cam_pixel`=0, `cam_hsync`=0, `cam_vsync`=0, `in_ready`=0, `underrun`=0, `sof_err`=0; divider, x and y counters = 0; FSM = IDLE. Reset mid-frame aborts the frame immediately.
- Clock divider:
  - `cam_clk` toggles every CLK_DIV cycles.
  - After reset release, the first rise is after CLK_DIV cycles and the first fall after 2*CLK_DIV cycles.
  - The divider free-runs in all states.
- Falling edge (F) = the cycle in which `cam_clk` registers 1->0. Every output except `cam_clk` and the sticky flags updates only at F, so the receiver samples on the `cam_clk` rising edge with data stable.
- Load cycle (L) = the cycle immediately before F.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE: syncs low, `cam_pixel`=0. At F with `enable`=1 -> ACTIVE, x=0, y=0. With `enable`=0 -> stay IDLE.
  - ACTIVE: one slot per F. x increments; after slot H_ACTIVE-1 -> HBLANK.
  - HBLANK: H_BLANK slots, `cam_hsync`=0, `cam_pixel`=0. At end: y++. Then y<V_ACTIVE -> ACTIVE, else -> VBLANK with y=0.
  - VBLANK: V_BLANK*(H_ACTIVE+H_BLANK) slots, both syncs low. At end -> ACTIVE if `enable`=1, else IDLE.
  - Dropping `enable` mid-frame completes the frame and its VBLANK.
- Sync levels:
  - `cam_hsync`=1 exactly in ACTIVE slots.
  - `cam_vsync`=1 in ACTIVE and HBLANK slots of lines 0..V_ACTIVE-1.
- Handshake:
  - `in_ready`=1 only in L when the upcoming slot is ACTIVE.
  - `in_valid`&`in_ready` in L: `in_pixel` appears on `cam_pixel` at the next F (latency 1 cycle).
  - `in_valid`=0 in such an L: that slot outputs 0 and `underrun` is set.
  - No buffering; a pixel is never accepted outside L.
- SOF check, on each accepted pixel:
  - `in_sof` must equal 1 iff x=0 and y=0; any mismatch sets `sof_err`.
  - Frames are not resynchronised on error.
- Widths: x and y are 12-bit counters; parameters must fit.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: CAMBUS_TX_TESTPAT_EN.
- Defined: while `show_test_pattern`=1, `in_ready` is held 0 and active-slot pixels are (x + y) mod 4096. `underrun` and `sof_err` are not updated.
  - The selection is sampled only at frame start (IDLE/VBLANK -> ACTIVE) and holds for the whole frame.
- Not defined: `show_test_pattern` is ignored and the stream is always used.

Test Plan:
- Common bench setting: CLK_DIV=2, H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, so slot=4 cycles, line=24, frame=96.
- Reset, `enable`=0 for 50 cycles -> `cam_clk` period 4 cycles, first fall at cycle 4, syncs 0, `in_ready` never 1.
- `enable`=1, source always valid with pixels 1..12, sof on 1 -> per line `cam_hsync` high 16 cycles then low 8; `cam_vsync` high 72 cycles then low 24; `cam_pixel` = 1..12 in order; no flags set.
- Withhold `in_valid` for the 6th pixel -> that slot `cam_pixel`=0, `underrun`=1 and stays 1; following pixels continue in order.
- Assert `in_sof` on the 3rd pixel -> `sof_err`=1; output timing unaffected.
- Drop `enable` on line 1, then assert reset at cycle 40 of a second run -> the first run finishes the frame plus 24 VBLANK cycles then IDLE; the reset clears all outputs next cycle.
- With CAMBUS_TX_TESTPAT_EN, `show_test_pattern`=1 -> line 1 pixels 1,2,3,4; `in_ready` stays 0; macro undefined -> stream pixels used.
